// File: rtl/jt49_bus_seq.sv
// jt49_bus_seq: command FIFO plus bus sequencer that turns queued
// write / read / wait / nop commands into JT49 PSG bus cycles.
// Writes get a setup clock, a WR_LEN strobe and a GAP idle, so that
// back-to-back writes to the same register (e.g. envelope reg 13) are
// always seen as separate strobes by the PSG.
module jt49_bus_seq #(
  parameter int FIFO_DEPTH = 4,
  parameter int WR_LEN     = 2,
  parameter int GAP        = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_op,
  input  logic [3:0] cmd_addr,
  input  logic [7:0] cmd_data,
  input  logic       sample,
  output logic [3:0] psg_addr,
  output logic [7:0] psg_din,
  output logic       psg_cs_n,
  output logic       psg_wr_n,
  input  logic [7:0] psg_dout,
  output logic       rd_valid,
  output logic [3:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       busy
);

  localparam int PW = $clog2(FIFO_DEPTH);

  localparam logic [1:0] OP_WR   = 2'b00;
  localparam logic [1:0] OP_RD   = 2'b01;
  localparam logic [1:0] OP_WAIT = 2'b10;

  localparam logic [3:0]  WR_M1   = 4'(WR_LEN - 1);
  localparam logic [3:0]  GAP_M1  = 4'(GAP - 1);
  localparam logic [3:0]  T_ONE   = 4'd1;
  localparam logic [7:0]  W_ONE   = 8'd1;
  localparam logic [PW-1:0] P_ONE = PW'(1);
  localparam logic [PW:0]   C_ONE = (PW+1)'(1);
  localparam logic [PW:0]   C_FULL = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE, SETUP, STROBE, HOLD, RADDR, RCAP, WAIT
  } state_t;

  state_t state;

  // command FIFO: {op, addr, data}
  logic [13:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [PW:0]   count;
  logic          full, empty, push, pop;
  logic [13:0]   head;
  logic [1:0]    h_op;
  logic [3:0]    h_addr;
  logic [7:0]    h_data;

  // sequencer working registers
  logic [3:0] tcnt;   // strobe / gap length counter
  logic [7:0] wcnt;   // remaining sample ticks for a wait
  logic [3:0] l_addr; // address of the read in flight

  assign full  = (count == C_FULL);
  assign empty = (count == '0);
  // no pass-through when full: a pop in the same cycle does not free a slot
  assign cmd_ready = ~full;
  assign push  = cmd_valid & ~full;
  // only IDLE consumes entries; count is pre-edge, so a fresh push waits a cycle
  assign pop   = (state == IDLE) & ~empty;

  assign head   = mem[rd_ptr];
  assign h_op   = head[13:12];
  assign h_addr = head[11:8];
  assign h_data = head[7:0];

  assign busy = ~empty | (state != IDLE);

  // FIFO storage: data only, validity is carried by count
  always_ff @(posedge clk) begin
    if (!rst && push) mem[wr_ptr] <= {cmd_op, cmd_addr, cmd_data};
  end

  // FIFO pointers and occupancy; simultaneous push+pop leaves count unchanged
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + P_ONE;
      if (pop)  rd_ptr <= rd_ptr + P_ONE;
      case ({push, pop})
        2'b10:   count <= count + C_ONE;
        2'b01:   count <= count - C_ONE;
        default: count <= count;
      endcase
    end
  end

  // bus sequencer FSM with registered bus outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      psg_addr <= '0;
      psg_din  <= '0;
      psg_cs_n <= 1'b1;
      psg_wr_n <= 1'b1;
      rd_valid <= 1'b0;
      rd_addr  <= '0;
      rd_data  <= '0;
      tcnt     <= '0;
      wcnt     <= '0;
      l_addr   <= '0;
    end else begin
      rd_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (!empty) begin
            case (h_op)
              OP_WR: begin
                psg_addr <= h_addr;
                psg_din  <= h_data;
                psg_cs_n <= 1'b0;
                psg_wr_n <= 1'b1;
                state    <= SETUP;
              end
              OP_RD: begin
                psg_addr <= h_addr;
                l_addr   <= h_addr;
                psg_cs_n <= 1'b1;
                psg_wr_n <= 1'b1;
                state    <= RADDR;
              end
              OP_WAIT: begin
                wcnt  <= h_data;
                state <= WAIT;
              end
              default: state <= IDLE; // nop: entry dropped
            endcase
          end
        end
        SETUP: begin
          psg_wr_n <= 1'b0;
          tcnt     <= WR_M1;
          state    <= STROBE;
        end
        STROBE: begin
          if (tcnt == '0) begin
            psg_cs_n <= 1'b1;
            psg_wr_n <= 1'b1;
            tcnt     <= GAP_M1;
            state    <= HOLD;
          end else begin
            tcnt <= tcnt - T_ONE;
          end
        end
        HOLD: begin
          if (tcnt == '0) state <= IDLE;
          else            tcnt  <= tcnt - T_ONE;
        end
        RADDR: state <= RCAP;
        RCAP: begin
          // psg_dout has had a full clock to follow psg_addr
          rd_data  <= psg_dout;
          rd_addr  <= l_addr;
          rd_valid <= 1'b1;
          tcnt     <= GAP_M1;
          state    <= HOLD;
        end
        WAIT: begin
          // exit one clock after reaching zero; never decrement past zero
          if (wcnt == '0)  state <= IDLE;
          else if (sample) wcnt  <= wcnt - W_ONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
